// File: rtl/filter_pkg.sv
// Shared definitions for the Filter shift-with-parity datapath: lane width,
// skid-buffer occupancy encoding and the per-word decode helper.
package filter_pkg;

   localparam int unsigned FILTER_WIDTH  = 16;
   localparam int unsigned UNSHIFT_MAX_W = 64;

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_ONE,
      ST_TWO
   } occ_state_t;

   // Undo one Filter step on a w-bit lane held zero-extended in UNSHIFT_MAX_W bits:
   // shift right and put the encoder carry-out back into the top lane bit.
   function automatic logic [UNSHIFT_MAX_W-1:0] unshift(
      input logic [UNSHIFT_MAX_W-1:0] data,
      input logic                     parity,
      input int unsigned              w
   );
      logic [UNSHIFT_MAX_W-1:0] lane_mask;
      lane_mask = '1;
      lane_mask = lane_mask >> (UNSHIFT_MAX_W - w);
      return ((data >> 1) & lane_mask) | (UNSHIFT_MAX_W'(parity) << (w - 1));
   endfunction

endpackage

// File: rtl/filter_skid.sv
// Generic 2-entry valid/ready skid buffer. Input ready is registered so there is
// no combinational path from out_ready back to in_ready.
module filter_skid
   import filter_pkg::*;
#(
   parameter int unsigned W = FILTER_WIDTH + 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready
);

   occ_state_t   state_q;
   occ_state_t   state_d;
   logic [W-1:0] main_q;
   logic [W-1:0] skid_q;
   logic         ready_q;
   logic         in_xfer;
   logic         out_xfer;
   logic         load_main_in;
   logic         load_main_skid;
   logic         load_skid;

   assign in_ready  = ready_q;
   assign out_valid = (state_q != ST_EMPTY);
   assign out_data  = main_q;
   assign in_xfer   = in_valid & ready_q;
   assign out_xfer  = out_valid & out_ready;

   always_comb begin
      state_d        = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            if (in_xfer) begin
               load_main_in = 1'b1;
               state_d      = ST_ONE;
            end
         end
         ST_ONE: begin
            if (in_xfer && out_xfer) begin
               load_main_in = 1'b1;
            end else if (in_xfer) begin
               load_skid = 1'b1;
               state_d   = ST_TWO;
            end else if (out_xfer) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (out_xfer) begin
               load_main_skid = 1'b1;
               state_d        = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   // Ready tracks the next occupancy, so it is already low in the cycle TWO is entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         ready_q <= 1'b0;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         ready_q <= (state_d != ST_TWO);
         if (load_main_in) begin
            main_q <= in_data;
         end else if (load_main_skid) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= in_data;
         end
      end
   end

endmodule

// File: rtl/filter_unshift.sv
// Receive-side decode for the Filter shift-with-parity encoding, with a skid
// buffer for back-pressure and a counter of delivered words.
module filter_unshift
   import filter_pkg::*;
#(
   parameter int unsigned WIDTH = FILTER_WIDTH,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] io_x_data,
   input  logic             io_x_valid,
   input  logic             io_x_parity,
   output logic             io_x_ready,
   output logic [WIDTH-1:0] io_y_data,
   output logic             io_y_valid,
   output logic             io_y_parity,
   input  logic             io_y_ready,
   output logic [CNT_W-1:0] io_count
);

   logic [WIDTH-1:0] dec_data;
   logic             dec_par;
   logic [WIDTH:0]   buf_out;
   logic [CNT_W-1:0] count_q;

   assign dec_data = WIDTH'(unshift(UNSHIFT_MAX_W'(io_x_data), io_x_parity, WIDTH));
   assign dec_par  = io_x_data[0];

   filter_skid #(
      .W (WIDTH + 1)
   ) u_skid (
      .clk       (clk),
      .rst_n     (reset),
      .in_data   ({dec_par, dec_data}),
      .in_valid  (io_x_valid),
      .in_ready  (io_x_ready),
      .out_data  (buf_out),
      .out_valid (io_y_valid),
      .out_ready (io_y_ready)
   );

   assign io_y_parity = buf_out[WIDTH];
   assign io_y_data   = buf_out[WIDTH-1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else if (io_y_valid && io_y_ready) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign io_count = count_q;

endmodule

// File: tb/tb_filter_unshift.sv
// Bench for filter_unshift: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_filter_unshift;

   localparam int unsigned W  = 16;
   localparam int unsigned CW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic [W-1:0]  x_data;
   logic          x_valid;
   logic          x_parity;
   logic          x_ready;
   logic [W-1:0]  y_data;
   logic          y_valid;
   logic          y_parity;
   logic          y_ready;
   logic [CW-1:0] count;

   logic [7:0]    w_x_data;
   logic          w_x_valid;
   logic          w_x_parity;
   logic          w_x_ready;
   logic [7:0]    w_y_data;
   logic          w_y_valid;
   logic          w_y_parity;
   logic          w_y_ready;
   logic [3:0]    w_count;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [W:0]    mq[$];
   logic [W:0]    orig_q[$];
   logic [CW-1:0] m_count = '0;
   logic          m_ready = 1'b0;
   bit            chk_en  = 1'b0;
   bit            rt_mode = 1'b0;
   bit            rt_done = 1'b0;

   always #5 clk = ~clk;

   filter_unshift #(
      .WIDTH (W),
      .CNT_W (CW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .io_x_data   (x_data),
      .io_x_valid  (x_valid),
      .io_x_parity (x_parity),
      .io_x_ready  (x_ready),
      .io_y_data   (y_data),
      .io_y_valid  (y_valid),
      .io_y_parity (y_parity),
      .io_y_ready  (y_ready),
      .io_count    (count)
   );

   filter_unshift #(
      .WIDTH (8),
      .CNT_W (4)
   ) dut4 (
      .clk         (clk),
      .reset       (reset),
      .io_x_data   (w_x_data),
      .io_x_valid  (w_x_valid),
      .io_x_parity (w_x_parity),
      .io_x_ready  (w_x_ready),
      .io_y_data   (w_y_data),
      .io_y_valid  (w_y_valid),
      .io_y_parity (w_y_parity),
      .io_y_ready  (w_y_ready),
      .io_count    (w_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a FIFO of at most two decoded words; ready is low the cycle after it fills
   // and for the first cycle out of reset.
   always @(negedge clk) begin
      bit         inx;
      bit         outx;
      logic [W:0] o;
      if (!reset) begin
         mq.delete();
         m_count = '0;
         m_ready = 1'b0;
      end
      if (chk_en) begin
         chk("y_valid", 32'(y_valid), 32'(mq.size() > 0));
         chk("x_ready", 32'(x_ready), 32'(m_ready));
         chk("count", 32'(count), 32'(m_count));
         if (mq.size() > 0) begin
            chk("y_data", 32'(y_data), 32'(mq[0][W-1:0]));
            chk("y_parity", 32'(y_parity), 32'(mq[0][W]));
         end
         if (reset && rt_mode && mq.size() > 0 && y_ready) begin
            chk("rt_orig_avail", 32'(orig_q.size() > 0), 32'd1);
            if (orig_q.size() > 0) begin
               o = orig_q.pop_front();
               chk("rt_data", 32'(y_data), 32'(o[W-1:0]));
               chk("rt_parity", 32'(y_parity), 32'(o[W]));
            end
         end
      end
      if (reset) begin
         inx  = x_valid && m_ready;
         outx = (mq.size() > 0) && y_ready;
         if (outx) begin
            void'(mq.pop_front());
            m_count++;
         end
         if (inx) mq.push_back({x_data[0], x_parity, x_data[W-1:1]});
         m_ready = (mq.size() < 2);
      end
   end

   task automatic send(input logic [W-1:0] d, input logic p);
      int n = 0;
      x_data   = d;
      x_parity = p;
      x_valid  = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!x_ready && n < 200);
      chk("send_accept", 32'(x_ready), 32'd1);
      @(posedge clk);
      #1;
      x_valid = 1'b0;
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      logic [W-1:0] xr;
      logic         pr;
      int           n;
      int           acc;

      reset      = 1'b0;
      x_data     = '0;
      x_valid    = 1'b0;
      x_parity   = 1'b0;
      y_ready    = 1'b0;
      w_x_data   = '0;
      w_x_valid  = 1'b0;
      w_x_parity = 1'b0;
      w_y_ready  = 1'b1;

      // reset values
      @(posedge clk);
      #1;
      chk("rst_x_ready", 32'(x_ready), 32'd0);
      chk("rst_y_valid", 32'(y_valid), 32'd0);
      chk("rst_y_data", 32'(y_data), 32'd0);
      chk("rst_y_parity", 32'(y_parity), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk_en = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b1;

      // single word
      y_ready = 1'b1;
      send(16'h2469, 1'b1);
      @(negedge clk);
      chk("single_valid", 32'(y_valid), 32'd1);
      chk("single_data", 32'(y_data), 32'h9234);
      chk("single_parity", 32'(y_parity), 32'd1);
      @(negedge clk);
      chk("single_count", 32'(count), 32'd1);
      @(posedge clk);
      #1;

      // round trip through a behavioural Filter encoder, with random output stalls
      rt_mode = 1'b1;
      rt_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               xr = W'($urandom);
               pr = 1'($urandom);
               orig_q.push_back({pr, xr});
               send({xr[W-2:0], pr}, xr[W-1]);
            end
            rt_done = 1'b1;
         end
         begin
            while (!rt_done) begin
               @(posedge clk);
               #1;
               y_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      y_ready = 1'b1;
      n = 0;
      while (mq.size() > 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("rt_drain", 32'(mq.size()), 32'd0);
      chk("rt_all_out", 32'(orig_q.size()), 32'd0);
      rt_mode = 1'b0;
      @(negedge clk);
      chk("rt_count", 32'(count), 32'd1001);
      @(posedge clk);
      #1;

      // stall hold: output must not move while the consumer refuses it
      y_ready = 1'b0;
      send(16'h1234, 1'b0);
      @(negedge clk);
      chk("stall_first", 32'(y_data), 32'h091A);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         x_valid = 1'b1;
         x_data  = W'($urandom);
         @(negedge clk);
         chk("stall_valid", 32'(y_valid), 32'd1);
         chk("stall_hold", 32'(y_data), 32'h091A);
      end
      @(posedge clk);
      #1;
      x_valid = 1'b0;
      y_ready = 1'b1;
      repeat (4) @(negedge clk);
      chk("stall_count", 32'(count), 32'd1003);

      // back-pressure: third word must wait for the consumer
      pulse_reset();
      y_ready = 1'b0;
      fork
         begin
            send(16'h0003, 1'b0);
            send(16'h8001, 1'b1);
            send(16'hFFFE, 1'b0);
         end
         begin
            repeat (4) @(negedge clk);
            chk("bp_ready_low", 32'(x_ready), 32'd0);
            chk("bp_valid", 32'(y_valid), 32'd1);
            chk("bp_head", 32'(y_data), 32'h0001);
            @(posedge clk);
            #1;
            y_ready = 1'b1;
         end
      join
      repeat (6) @(negedge clk);
      chk("bp_count", 32'(count), 32'd3);

      // counter wrap on a 4-bit counter
      n   = 0;
      acc = 0;
      @(posedge clk);
      #1;
      w_x_valid = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         chk("wrap_seq", 32'(w_count), 32'(n % 16));
         if (w_y_valid) n++;
         if (w_x_valid && w_x_ready) acc++;
         @(posedge clk);
         #1;
         if (acc >= 17) w_x_valid = 1'b0;
         w_x_data = w_x_data + 8'd1;
      end
      @(negedge clk);
      chk("wrap_transfers", 32'(n), 32'd17);
      chk("wrap_final", 32'(w_count), 32'd1);
      @(posedge clk);
      #1;

      // reset while two words are buffered
      y_ready = 1'b0;
      send(16'h1111, 1'b0);
      send(16'h2222, 1'b1);
      reset = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(y_valid), 32'd0);
      chk("mid_rst_count", 32'(count), 32'd0);
      chk("mid_rst_ready", 32'(x_ready), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      chk("post_rst_ready0", 32'(x_ready), 32'd0);
      @(negedge clk);
      chk("post_rst_ready1", 32'(x_ready), 32'd1);
      @(posedge clk);
      #1;
      y_ready = 1'b1;
      send(16'hABCD, 1'b0);
      @(negedge clk);
      chk("post_rst_valid", 32'(y_valid), 32'd1);
      chk("post_rst_data", 32'(y_data), 32'h55E6);
      chk("post_rst_parity", 32'(y_parity), 32'd1);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
